// File: rtl/ultrasonic_scan_scheduler.sv
// ultrasonic_scan_scheduler
//   Round-robin ping scheduler for four ultrasonic ranging sensors. Each ping
//   drives one trigger pulse, waits for the echo, measures the echo-high time
//   in millimetres and reports one result. A dead time follows each ping.
//
// Ports
//   clk          in   system clock, all logic on the rising edge
//   rst          in   synchronous reset, active-high
//   on_off       in   scan enable; high keeps scanning
//   echo[3:0]    in   asynchronous echo lines, bit n = sensor n
//   sensor_en    in   [3:0] per-sensor enable (only with ULTRASONIC_SCAN_MASK_EN)
//   trig[3:0]    out  trigger lines, at most one bit high
//   dist_valid   out  one-cycle pulse, result fields valid
//   dist_id      out  [1:0] sensor index of the result
//   dist_mm      out  [9:0] measured distance in mm (1023 on timeout)
//   dist_timeout out  result is a no-object timeout
//   busy         out  high whenever the scheduler is not idle
//
// Build option
//   ULTRASONIC_SCAN_MASK_EN  adds sensor_en; disabled sensors are skipped and
//                            an all-zero mask keeps the block idle.

module ultrasonic_scan_scheduler #(
  parameter int unsigned TRIG_CYCLES    = 500,
  parameter int unsigned TICKS_PER_MM   = 291,
  parameter int unsigned TIMEOUT_CYCLES = 1900000,
  parameter int unsigned HOLDOFF_CYCLES = 3000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       on_off,
  input  logic [3:0] echo,
`ifdef ULTRASONIC_SCAN_MASK_EN
  input  logic [3:0] sensor_en,
`endif
  output logic [3:0] trig,
  output logic       dist_valid,
  output logic [1:0] dist_id,
  output logic [9:0] dist_mm,
  output logic       dist_timeout,
  output logic       busy
);

  localparam int unsigned TRIG_W = $clog2(TRIG_CYCLES + 1);
  localparam int unsigned SUB_W  = $clog2(TICKS_PER_MM + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(HOLDOFF_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLDOFF
  } state_t;

  state_t            state, state_nx;
  logic [1:0]        cur, cur_nx;
  logic [3:0]        echo_meta, echo_sync;
  logic [TRIG_W-1:0] trig_cnt;
  logic [SUB_W-1:0]  sub_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [9:0]        mm_cnt;
  logic              echo_cur;
  logic              to_hit;
  logic              emit, emit_to;
  logic [3:0]        en_mask;
  logic              any_en;

`ifdef ULTRASONIC_SCAN_MASK_EN
  assign en_mask = sensor_en;
`else
  assign en_mask = '1;
`endif
  assign any_en = |en_mask;

  // First enabled index starting at base (inclusive) or after base (skip_self).
  function automatic logic [1:0] pick_next(input logic [1:0] base,
                                           input logic [3:0] en,
                                           input logic       skip_self);
    logic [1:0] idx;
    logic [1:0] res;
    logic       found;
    res   = base;
    found = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = base + 2'(k) + {1'b0, skip_self};
      if (!found && en[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign echo_cur = echo_sync[cur];
  // The increment made this cycle brings the timeout counter to its limit.
  assign to_hit   = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign busy     = (state != IDLE);

  always_comb begin
    trig = '0;
    if (state == TRIG) trig[cur] = 1'b1;
  end

  always_comb begin
    state_nx = state;
    cur_nx   = cur;
    emit     = 1'b0;
    emit_to  = 1'b0;
    case (state)
      IDLE: begin
        if (on_off && any_en) begin
          state_nx = TRIG;
          cur_nx   = pick_next(cur, en_mask, 1'b0);
        end
      end
      TRIG: begin
        if (trig_cnt == TRIG_W'(TRIG_CYCLES - 1)) state_nx = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (to_hit) begin
          emit     = 1'b1;
          emit_to  = 1'b1;
          state_nx = HOLDOFF;
        end else if (echo_cur) begin
          state_nx = MEASURE;
        end
      end
      MEASURE: begin
        if (to_hit) begin
          emit     = 1'b1;
          emit_to  = 1'b1;
          state_nx = HOLDOFF;
        end else if (!echo_cur) begin
          emit     = 1'b1;
          state_nx = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (hold_cnt == HOLD_W'(HOLDOFF_CYCLES - 1)) begin
          cur_nx   = pick_next(cur, en_mask, 1'b1);
          state_nx = (on_off && any_en) ? TRIG : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cur          <= '0;
      echo_meta    <= '0;
      echo_sync    <= '0;
      trig_cnt     <= '0;
      sub_cnt      <= '0;
      to_cnt       <= '0;
      hold_cnt     <= '0;
      mm_cnt       <= '0;
      dist_valid   <= 1'b0;
      dist_id      <= '0;
      dist_mm      <= '0;
      dist_timeout <= 1'b0;
    end else begin
      echo_meta <= echo;
      echo_sync <= echo_meta;
      state     <= state_nx;
      cur       <= cur_nx;

      trig_cnt <= (state == TRIG && state_nx == TRIG) ? trig_cnt + 1'b1 : '0;
      hold_cnt <= (state == HOLDOFF && state_nx == HOLDOFF) ? hold_cnt + 1'b1 : '0;
      to_cnt   <= (state == WAIT_RISE || state == MEASURE) ? to_cnt + 1'b1 : '0;

      if (state == WAIT_RISE) begin
        sub_cnt <= '0;
        mm_cnt  <= '0;
      end else if (state == MEASURE && echo_cur) begin
        // mm advances on the first echo-high cycle of each TICKS_PER_MM window,
        // crediting the rising-edge cycle that was spent in WAIT_RISE.
        if (sub_cnt == '0 && mm_cnt != '1) mm_cnt <= mm_cnt + 1'b1;
        sub_cnt <= (sub_cnt == SUB_W'(TICKS_PER_MM - 1)) ? '0 : sub_cnt + 1'b1;
      end

      dist_valid <= emit;
      if (emit) begin
        dist_id      <= cur;
        dist_mm      <= emit_to ? '1 : mm_cnt;
        dist_timeout <= emit_to;
      end
    end
  end

endmodule
